// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI master controller.
package spi_master_pkg;

  localparam int CMD_W  = 10;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TURN, RECV, GAP} state_e;

endpackage

// File: rtl/spi_master_shifter.sv
// MSB-first TX shift register (parallel load) and RX capture shifter.
module spi_master_shifter
  import spi_master_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [CMD_W-1:0]  load_data,
  input  logic              shift_en,
  input  logic              cap_en,
  input  logic              miso,
  output logic              tx_msb,
  output logic              tx_next,
  output logic [DATA_W-1:0] rx_next
);

  logic [CMD_W-1:0]  tx_sh;
  // only the seven earlier bits are stored; the newest bit comes straight from miso
  logic [DATA_W-2:0] rx_sh;

  assign tx_msb  = tx_sh[CMD_W-1];
  assign tx_next = tx_sh[CMD_W-2];
  assign rx_next = {rx_sh, miso};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh <= '0;
      rx_sh <= '0;
    end else begin
      if (load)          tx_sh <= load_data;
      else if (shift_en) tx_sh <= {tx_sh[CMD_W-2:0], 1'b0};
      if (load)          rx_sh <= '0;
      else if (cap_en)   rx_sh <= rx_next[DATA_W-2:0];
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: turns 10-bit RAM commands into SS_n/MOSI frames, reads 8 bits on MISO.
// Optional SPIM_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module spi_master_ctrl
  import spi_master_pkg::*;
#(
  parameter int unsigned LEAD_CYCLES = 1,
  parameter int unsigned TURN_CYCLES = 2,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              MOSI,
  output logic              SS_n,
  input  logic              MISO
`ifdef SPIM_FRAME_CNT_EN
  , output logic [15:0]     frame_cnt
`endif
);

  localparam logic [CNT_W-1:0] LEAD_LD  = CNT_W'(LEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHIFT_LD = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] TURN_LD  = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] RECV_LD  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rd_q, rd_d;
  logic               mosi_d, rsp_valid_d;
  logic               load, shift_en, cap_en;
  logic               tx_msb, tx_next;
  logic [DATA_W-1:0]  rx_next;

  spi_master_shifter u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (cmd_data),
    .shift_en  (shift_en),
    .cap_en    (cap_en),
    .miso      (MISO),
    .tx_msb    (tx_msb),
    .tx_next   (tx_next),
    .rx_next   (rx_next)
  );

  // cnt counts down the remaining cycles of the current state; 0 means last cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    mosi_d      = 1'b0;
    rsp_valid_d = 1'b0;
    load        = 1'b0;
    shift_en    = 1'b0;
    cap_en      = 1'b0;
    unique case (state_q)
      IDLE: if (cmd_valid && cmd_ready) begin
        load    = 1'b1;
        rd_d    = (cmd_data[CMD_W-1 -: 2] == OP_RD_DATA);
        mosi_d  = cmd_data[CMD_W-1];
        state_d = LEAD;
        cnt_d   = LEAD_LD;
      end
      LEAD: begin
        mosi_d = tx_msb;
        if (cnt_q == '0) begin
          state_d = SHIFT;
          cnt_d   = SHIFT_LD;
        end else cnt_d = cnt_q - 1'b1;
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          if (!rd_q) begin
            state_d = GAP;
            cnt_d   = GAP_LD;
          end else if (TURN_CYCLES == 0) begin
            state_d = RECV;
            cnt_d   = RECV_LD;
          end else begin
            state_d = TURN;
            cnt_d   = TURN_LD;
          end
        end else begin
          shift_en = 1'b1;
          mosi_d   = tx_next;
          cnt_d    = cnt_q - 1'b1;
        end
      end
      TURN: begin
        if (cnt_q == '0) begin
          state_d = RECV;
          cnt_d   = RECV_LD;
        end else cnt_d = cnt_q - 1'b1;
      end
      RECV: begin
        cap_en = 1'b1;
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          state_d     = GAP;
          cnt_d       = GAP_LD;
        end else cnt_d = cnt_q - 1'b1;
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // every pin is registered from the next state, so it changes on the entry edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      SS_n      <= !(state_d inside {LEAD, SHIFT, TURN, RECV});
      MOSI      <= mosi_d;
      cmd_ready <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      rsp_valid <= rsp_valid_d;
      if (rsp_valid_d) rsp_data <= rx_next;
    end
  end

`ifdef SPIM_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   frame_cnt <= '0;
    else if (state_d == GAP && state_q != GAP)    frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: frame-level reference model, slave+RAM emulation, directed tests.
module tb_spi_master_ctrl;

  localparam int LEAD = 1, TURN = 2, GAP = 1;

  logic       clk = 0, rst_n = 0, cmd_valid = 0, MISO = 0;
  logic [9:0] cmd_data = '0;
  logic       cmd_ready, rsp_valid, busy, MOSI, SS_n;
  logic [7:0] rsp_data;
`ifdef SPIM_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  always #5 clk = ~clk;

  spi_master_ctrl #(.LEAD_CYCLES(LEAD), .TURN_CYCLES(TURN), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .MOSI(MOSI), .SS_n(SS_n), .MISO(MISO)
`ifdef SPIM_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  int total = 0, bad = 0;

  // ---------------- reference model: one queue entry per expected cycle ----------------
  typedef struct packed {logic ss_n, mosi, ready, busy, rv, recv, fc;} ent_t;
  ent_t q[$];
  ent_t cur, ended;
  logic [7:0]  m_rx, m_rsp;
  logic [15:0] m_fcnt;

  function automatic ent_t mk(logic s, logic m, logic r, logic b, logic v, logic rc, logic f);
    return {s, m, r, b, v, rc, f};
  endfunction

  task automatic push_frame(input logic [9:0] c);
    logic rd;
    rd = (c[9:8] == 2'b11);
    for (int i = 0; i < LEAD; i++) q.push_back(mk(0, c[9], 0, 1, 0, 0, 0));
    for (int i = 0; i < 10; i++)   q.push_back(mk(0, c[9-i], 0, 1, 0, 0, 0));
    if (rd) begin
      for (int i = 0; i < TURN; i++) q.push_back(mk(0, 0, 0, 1, 0, 0, 0));
      for (int i = 0; i < 8; i++)    q.push_back(mk(0, 0, 0, 1, 0, 1, 0));
    end
    for (int i = 0; i < GAP; i++) q.push_back(mk(1, 0, 0, 1, rd && (i == 0), 0, i == 0));
  endtask

  initial begin
    cur = mk(1, 0, 1, 0, 0, 0, 0); m_rx = '0; m_rsp = '0; m_fcnt = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete(); cur = mk(1, 0, 1, 0, 0, 0, 0); m_rx = '0; m_rsp = '0; m_fcnt = '0;
      end else begin
        ended = cur;
        if (ended.recv) m_rx = {m_rx[6:0], MISO};
        if (ended.ready && cmd_valid) push_frame(cmd_data);
        cur = (q.size() > 0) ? q.pop_front() : mk(1, 0, 1, 0, 0, 0, 0);
        if (cur.rv) m_rsp = m_rx;
        if (cur.fc) m_fcnt = m_fcnt + 16'd1;
      end
    end
  end

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    total++;
    if ({SS_n, MOSI, cmd_ready, busy, rsp_valid, rsp_data} !==
        {cur.ss_n, cur.mosi, cur.ready, cur.busy, cur.rv, m_rsp}) begin
      bad++;
      $display("FAIL cycle_check t=%0t: got ss_n/mosi/ready/busy/rv=%b%b%b%b%b rsp=%h, want %b%b%b%b%b rsp=%h",
               $time, SS_n, MOSI, cmd_ready, busy, rsp_valid, rsp_data,
               cur.ss_n, cur.mosi, cur.ready, cur.busy, cur.rv, m_rsp);
    end
`ifdef SPIM_FRAME_CNT_EN
    total++;
    if (frame_cnt !== m_fcnt) begin
      bad++;
      $display("FAIL frame_cnt_check t=%0t: got %0d want %0d", $time, frame_cnt, m_fcnt);
    end
`endif
  end

  // ---------------- bus monitor (feeds literal checks) ----------------
  int cyc = 0, len = 0, last_len = 0, frames = 0, rv_cnt = 0;
  int hi_len = 0, gap_min = 1000, last_fall = 0, fall_period = 0;
  logic in_frame = 0;
  logic [9:0] bits = '0, last_bits = '0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!SS_n) begin
      if (!in_frame) begin
        in_frame = 1; len = 0; bits = '0; frames++;
        fall_period = cyc - last_fall; last_fall = cyc;
        if (hi_len < gap_min) gap_min = hi_len;
      end
      if (len >= LEAD && len < LEAD + 10) bits = {bits[8:0], MOSI};
      len++; hi_len = 0;
    end else begin
      if (in_frame) begin in_frame = 0; last_len = len; last_bits = bits; end
      hi_len++;
    end
    if (rsp_valid) rv_cnt++;
  end

  // ---------------- slave + RAM emulation ----------------
  logic [7:0] ram [256];
  logic [7:0] s_addr = '0, s_raddr = '0, rd_byte = '0;
  logic [9:0] sh = '0;
  logic       rdphase = 0;
  int         pos = 0;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    ram[0] = 8'hC3;
    forever begin
      @(posedge clk);
      if (!SS_n) begin
        if (pos >= LEAD && pos < LEAD + 10) sh = {sh[8:0], MOSI};
        if (pos == LEAD + 9) begin
          case (sh[9:8])
            2'b00: s_addr = sh[7:0];
            2'b01: ram[s_addr] = sh[7:0];
            2'b10: s_raddr = sh[7:0];
            default: begin rd_byte = ram[s_raddr]; rdphase = 1; end
          endcase
        end
        pos++;
      end else begin
        pos = 0; rdphase = 0;
      end
      #1;
      MISO = 0;
      if (!SS_n && rdphase && pos >= LEAD + 10 + TURN && pos < LEAD + 18 + TURN)
        MISO = rd_byte[7 - (pos - (LEAD + 10 + TURN))];
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send(input logic [9:0] c);
    bit ok = 0;
    cmd_valid = 1; cmd_data = c;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 0;
    if (!ok) begin bad++; total++; $display("FAIL send_timeout: got no cmd_ready want cmd_ready for %h", c); end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy && SS_n) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    if (!ok) begin bad++; total++; $display("FAIL idle_timeout: got busy want idle"); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  int f0;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ss_n", SS_n, 1);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_rsp_data", rsp_data, 0);
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;

    // write-address 0x0A5
    rv_cnt = 0;
    send(10'h0A5); wait_idle();
    chk("wa_len", last_len, 11);
    chk("wa_bits", last_bits, 10'h0A5);
    chk("wa_no_rsp", rv_cnt, 0);

    // read-data: slave RAM[0]=C3 drives 1,1,0,0,0,0,1,1
    send(10'h300); wait_idle();
    chk("rd_len", last_len, 21);
    chk("rd_data", rsp_data, 8'hC3);
    chk("rd_one_pulse", rv_cnt, 1);

    // command while busy is dropped
    f0 = frames;
    send(10'h0C3);
    repeat (3) @(posedge clk);
    #1 cmd_valid = 1; cmd_data = 10'h1FF;
    @(posedge clk); #1 cmd_valid = 0;
    wait_idle();
    chk("drop_frames", frames - f0, 1);
    chk("drop_bits", last_bits, 10'h0C3);
    send(10'h1FF); wait_idle();
    chk("drop_later_frames", frames - f0, 2);
    chk("drop_later_bits", last_bits, 10'h1FF);

    // back-to-back through slave+RAM
    gap_min = 1000; rv_cnt = 0;
    send(10'h010); send(10'h15A); send(10'h210); send(10'h300);
    wait_idle();
    chk("b2b_data", rsp_data, 8'h5A);
    chk("b2b_gap_ok", gap_min >= 1, 1);
    chk("b2b_period", fall_period, 13);
    chk("b2b_one_pulse", rv_cnt, 1);

    // reset during RECV bit 4
    rv_cnt = 0;
    send(10'h300);
    repeat (LEAD + 10 + TURN + 4) @(posedge clk);
    #2 rst_n = 0;
    #1 chk("rst_ss_n_immediate", SS_n, 1);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    chk("rst_no_rsp", rv_cnt, 0);
    chk("rst_rsp_data", rsp_data, 0);
    send(10'h300); wait_idle();
    chk("post_rst_data", rsp_data, 8'h5A);
    chk("post_rst_len", last_len, 21);
    chk("post_rst_pulse", rv_cnt, 1);
`ifdef SPIM_FRAME_CNT_EN
    send(10'h011); send(10'h122); wait_idle();
    chk("frame_cnt_three", frame_cnt, 3);
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
